fibonacci_stream: RTL
=====================

FIBONACCI_STREAM -- requirements
Module: fibonacci_stream

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the bit width of every sequence term and seed.
REQ-002 Parameter COUNT_WIDTH, default 8, SHALL set the width of the length input and the internal term counter.
REQ-003 Parameter OVF_MODE, default 0, SHALL select overflow handling: 0 = wrap modulo 2^DATA_WIDTH; 1 = stop before the first overflowed term.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 Port resetn, input, 1, SHALL be the reset: synchronous and active-high (reset when 1).
REQ-006 Port start, input, 1, SHALL request a new sequence.
REQ-007 Port seed_a, input, DATA_WIDTH, SHALL be the first term; sampled on an accepted start.
REQ-008 Port seed_b, input, DATA_WIDTH, SHALL be the second term; sampled on an accepted start.
REQ-009 Port length, input, COUNT_WIDTH, SHALL be the maximum number of terms to emit; sampled on an accepted start.
REQ-010 Port out_ready, input, 1, SHALL be the downstream ready.
REQ-011 Port out_valid, output, 1, SHALL flag a valid term on out_data.
REQ-012 Port out_data, output, DATA_WIDTH, SHALL carry the current term.
REQ-013 Port out_last, output, 1, SHALL mark the final term of the sequence; qualified by out_valid.
REQ-014 Port busy, output, 1, SHALL be high while in state RUN.
REQ-015 Port overflow, output, 1, SHALL be a sticky flag, cleared on an accepted start.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and RUN; busy = (state == RUN).
REQ-017 In IDLE, start=1 with length!=0 SHALL load a=seed_a, b=seed_b, a_ovf=0, b_ovf=0, cnt=0, len=length, clear overflow and enter RUN next cycle.
REQ-018 start with length==0 SHALL be ignored: remain in IDLE, no state change.
REQ-019 start while in RUN SHALL be ignored.
REQ-020 In RUN, out_valid SHALL be 1 and out_data SHALL equal register a; in IDLE, out_valid=0 and out_last=0.
REQ-021 A handshake SHALL occur in any cycle with out_valid=1 and out_ready=1.
REQ-022 out_data and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-023 out_last SHALL be (cnt == len-1), OR'd with b_ovf when OVF_MODE=1.
REQ-024 A handshake with out_last=1 SHALL return the FSM to IDLE next cycle; a, b and cnt hold their values.
REQ-025 A handshake with out_last=0 SHALL update a<=b, a_ovf<=b_ovf, b<=(a+b) mod 2^DATA_WIDTH, b_ovf<=carry-out of a+b, cnt<=cnt+1.
REQ-026 The sum SHALL be computed DATA_WIDTH+1 bits wide; the MSB is the carry.
REQ-027 OVF_MODE=0: a handshake of a term with a_ovf=1 SHALL set overflow; terms continue as modulo-2^DATA_WIDTH sums of the wrapped values.
REQ-028 OVF_MODE=1: a handshake with out_last=1 and b_ovf=1 SHALL set overflow; no wrapped term is ever emitted.
REQ-029 If cnt==len-1 and b_ovf=1 coincide in OVF_MODE=1, the stream SHALL end on that term and overflow SHALL be set.
REQ-030 Throughput SHALL be one term per cycle with out_ready held high; the first term is valid the cycle after an accepted start.

Reset
REQ-031 resetn=1 at a clock edge SHALL force IDLE, out_valid=0, out_last=0, busy=0, overflow=0, out_data=0, a=b=cnt=0, a_ovf=b_ovf=0, regardless of state or handshake in that cycle.
REQ-032 Reset SHALL take priority over start and over a simultaneous handshake.

Verification
REQ-033 DATA_WIDTH=8, OVF_MODE=0, seeds 0/1, length 10, ready=1 -> 0,1,1,2,3,5,8,13,21,34 on consecutive cycles; out_last only on 34; overflow=0; busy drops the cycle after.
REQ-034 OVF_MODE=1, seeds 1/1, length 20 -> 13 beats 1,1,2,...,144,233; out_last on 233; overflow=1 after that handshake.
REQ-035 OVF_MODE=0, seeds 1/1, length 16 -> 14th term 121 sets overflow, then 98, 219; out_last on 219 (16th).
REQ-036 Backpressure: out_ready low 3 cycles mid-stream -> out_data/out_last held; no term skipped or duplicated.
REQ-037 start with length=0 -> no out_valid, busy=0; start asserted during RUN -> sequence unaffected.
REQ-038 resetn=1 mid-stream during a handshake -> next cycle out_valid=0, overflow=0, busy=0; a new start restarts from fresh seeds.

Source files
------------

// File: rtl/fibonacci_stream.sv
// Streams the Fibonacci sequence from two seeds over a valid/ready interface.
// Each accepted start emits up to `length` terms. Overflow is either wrapped
// (OVF_MODE=0) or ends the stream on the last representable term
// (OVF_MODE=1).
module fibonacci_stream #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int OVF_MODE    = 0
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    input  logic [DATA_WIDTH-1:0]  seed_a,
    input  logic [DATA_WIDTH-1:0]  seed_b,
    input  logic [COUNT_WIDTH-1:0] length,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overflow
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_nxt;
    logic [DATA_WIDTH-1:0]  a, b;
    logic                   a_ovf, b_ovf;
    logic [COUNT_WIDTH-1:0] cnt, len;
    logic                   load, advance, set_ovf, handshake;
    logic [DATA_WIDTH:0]    sum;

    // Full-width add: the extra MSB is the carry out of the term width.
    function automatic logic [DATA_WIDTH:0] add_carry(input logic [DATA_WIDTH-1:0] x,
                                                      input logic [DATA_WIDTH-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    assign sum       = add_carry(a, b);
    assign out_valid = (state == RUN);
    assign busy      = (state == RUN);
    assign out_data  = a;
    assign handshake = out_valid && out_ready;

    // Last-term detection; in stop mode a pending carry in b also ends the stream.
    always_comb begin
        out_last = 1'b0;
        if (state == RUN) begin
            out_last = (cnt == (len - 1'b1));
            if (OVF_MODE != 0)
                out_last = out_last || b_ovf;
        end
    end

    // Next-state and control strobes for the IDLE/RUN controller.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        advance   = 1'b0;
        set_ovf   = 1'b0;
        case (state)
            IDLE: begin
                if (start && (length != '0)) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (handshake) begin
                    if (out_last)
                        state_nxt = IDLE;
                    else
                        advance = 1'b1;
                end
                if (OVF_MODE != 0)
                    set_ovf = handshake && out_last && b_ovf;
                else
                    set_ovf = handshake && a_ovf;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State and term registers; reset wins over start and any handshake.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state    <= IDLE;
            a        <= '0;
            b        <= '0;
            a_ovf    <= 1'b0;
            b_ovf    <= 1'b0;
            cnt      <= '0;
            len      <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                a        <= seed_a;
                b        <= seed_b;
                a_ovf    <= 1'b0;
                b_ovf    <= 1'b0;
                cnt      <= '0;
                len      <= length;
                overflow <= 1'b0;
            end else begin
                if (advance) begin
                    a     <= b;
                    a_ovf <= b_ovf;
                    b     <= sum[DATA_WIDTH-1:0];
                    b_ovf <= sum[DATA_WIDTH];
                    cnt   <= cnt + 1'b1;
                end
                if (set_ovf)
                    overflow <= 1'b1;
            end
        end
    end

endmodule
